// File: rtl/iddr_align_pkg.sv
`default_nettype none
// ============================================================================
// Module : iddr_align_pkg
// Brief  : Shared types and widths for the IDDR alignment controller.
// Rev    : 1.0  initial release
// ============================================================================
package iddr_align_pkg;

  localparam int WORD_W = 8;
  localparam int OFF_W  = 3;
  localparam int PH_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_VERIFY = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ddr_gearbox_2to8.sv
`default_nettype none
// ============================================================================
// Module : ddr_gearbox_2to8
// Brief  : Gears Q0/Q1 pairs into a 16-bit history and windows an 8-bit word.
// Rev    : 1.0  initial release
// ============================================================================
module ddr_gearbox_2to8
  import iddr_align_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              q0_i,
  input  logic              q1_i,
  input  logic [OFF_W-1:0]  off_i,
  output logic [WORD_W-1:0] word_o,
  output logic              strobe_o
);

  logic [2*WORD_W-1:0] r_sr;
  logic [2*WORD_W-1:0] w_sr_next;
  logic [PH_W-1:0]     r_ph;

  // Newest bits land in the LSBs, Q0 ahead of Q1
  assign w_sr_next = {r_sr[2*WORD_W-3:0], q0_i, q1_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sr <= '0;
      r_ph <= '0;
    end else begin
      r_sr <= w_sr_next;
      if (clear_i) r_ph <= '0;
      else         r_ph <= r_ph + 2'd1;
    end
  end

  assign strobe_o = (&r_ph) && !clear_i;
  assign word_o   = w_sr_next[off_i +: WORD_W];

endmodule
`default_nettype wire

// File: rtl/iddr_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module : iddr_align_ctrl
// Brief  : Bit-offset search, verify and lock controller for a 1:2 IDDR.
// Rev    : 1.0  initial release
// ============================================================================
module iddr_align_ctrl
  import iddr_align_pkg::*;
#(
  parameter logic [7:0] TRAIN_PAT   = 8'h6A,
  parameter int         MATCH_COUNT = 4,
  parameter int         MAX_ROUNDS  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              relock_i,
  input  logic              ddr_q0_i,
  input  logic              ddr_q1_i,
  output logic              iddr_clear_o,
  output logic [WORD_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              locked_o,
  output logic              err_o,
  output logic [OFF_W-1:0]  offset_o
);

  localparam logic [3:0] c_match_lim = 4'(MATCH_COUNT);
  localparam logic [7:0] c_slip_lim  = 8'(8 * MAX_ROUNDS);

  state_e              r_state, w_state_next;
  logic [OFF_W-1:0]    r_off, w_off_next;
  logic                r_skip, w_skip_next;
  logic [3:0]          r_match_cnt, w_match_next, w_match_inc;
  logic [7:0]          r_slip_cnt, w_slip_next, w_slip_inc;
  logic [WORD_W-1:0]   r_data, w_data_next;
  logic                r_valid, w_valid_next;
  logic [WORD_W-1:0]   w_word;
  logic                w_strobe;

  ddr_gearbox_2to8 u_gearbox (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (r_state == ST_IDLE),
    .q0_i     (ddr_q0_i),
    .q1_i     (ddr_q1_i),
    .off_i    (r_off),
    .word_o   (w_word),
    .strobe_o (w_strobe)
  );

  assign w_match_inc = r_match_cnt + 4'd1;
  assign w_slip_inc  = r_slip_cnt + 8'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_off       <= '0;
      r_skip      <= 1'b0;
      r_match_cnt <= '0;
      r_slip_cnt  <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_off       <= w_off_next;
      r_skip      <= w_skip_next;
      r_match_cnt <= w_match_next;
      r_slip_cnt  <= w_slip_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_off_next   = r_off;
    w_skip_next  = r_skip;
    w_match_next = r_match_cnt;
    w_slip_next  = r_slip_cnt;
    w_data_next  = r_data;
    w_valid_next = 1'b0;

    if (!en_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_SEARCH;
          w_skip_next  = 1'b1;
          w_match_next = '0;
          w_slip_next  = '0;
        end
        ST_SEARCH, ST_VERIFY: begin
          if (w_strobe) begin
            if (r_skip) begin
              w_skip_next = 1'b0;
            end else if (w_word == TRAIN_PAT) begin
              // match_cnt is 0 in SEARCH, so one path covers both states
              w_match_next = w_match_inc;
              w_state_next = (w_match_inc >= c_match_lim) ? ST_LOCKED : ST_VERIFY;
            end else begin
              w_match_next = '0;
              w_slip_next  = w_slip_inc;
              if (w_slip_inc == c_slip_lim) begin
                w_state_next = ST_FAIL;
              end else begin
                w_state_next = ST_SEARCH;
                w_off_next   = r_off + 3'd1;
                w_skip_next  = 1'b1;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (relock_i) begin
            w_state_next = ST_SEARCH;
            w_skip_next  = 1'b1;
            w_match_next = '0;
            w_slip_next  = '0;
          end else if (w_strobe) begin
            w_data_next  = w_word;
            w_valid_next = 1'b1;
          end
        end
        ST_FAIL: begin
          if (relock_i) begin
            w_state_next = ST_SEARCH;
            w_skip_next  = 1'b1;
            w_match_next = '0;
            w_slip_next  = '0;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  assign iddr_clear_o = (r_state == ST_IDLE);
  assign locked_o     = (r_state == ST_LOCKED);
  assign err_o        = (r_state == ST_FAIL);
  assign data_o       = r_data;
  assign data_valid_o = r_valid;
  assign offset_o     = r_off;

endmodule
`default_nettype wire

// File: tb/tb_iddr_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_iddr_align_ctrl
// Brief  : Scenario bench for iddr_align_ctrl with a data_o scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_iddr_align_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b0;
  logic       relock_i = 1'b0;
  logic       ddr_q0_i = 1'b0;
  logic       ddr_q1_i = 1'b0;
  logic       iddr_clear_o;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       locked_o;
  logic       err_o;
  logic [2:0] offset_o;

  bit         bitq[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         passed = 0;

  iddr_align_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .relock_i     (relock_i),
    .ddr_q0_i     (ddr_q0_i),
    .ddr_q1_i     (ddr_q1_i),
    .iddr_clear_o (iddr_clear_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .locked_o     (locked_o),
    .err_o        (err_o),
    .offset_o     (offset_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) bitq.push_back(w[i]);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) bitq.push_back(1'b0);
  endtask

  // Two filler bits are eaten on the enabling edge; the rest places
  // word boundaries at bit offset k relative to the strobe
  task automatic start_stream(input int k);
    bitq.delete();
    push_zeros(2 + ((8 - k) % 8));
  endtask

  // One clock: drive the next bit pair, sample #1 after the edge, score data
  task automatic step();
    logic [7:0] exp;
    ddr_q0_i = 1'b0;
    ddr_q1_i = 1'b0;
    if (bitq.size() > 0) ddr_q0_i = bitq.pop_front();
    if (bitq.size() > 0) ddr_q1_i = bitq.pop_front();
    @(posedge clk_i);
    #1;
    if (data_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: data_valid_o=1 data_o=%h, no word expected", data_o);
      end else begin
        exp = exp_q.pop_front();
        if (data_o !== exp) $display("FAIL sb_data: data_o=%h expected %h", data_o, exp);
        else passed++;
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    en_i = 1'b0;
    relock_i = 1'b0;
    bitq.delete();
    exp_q.delete();
    repeat (3) step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (iddr_clear_o !== 1'b1) $display("FAIL rst_clear: got %b want 1", iddr_clear_o); else passed++;
    checks++; if (data_o !== 8'h00) $display("FAIL rst_data: got %h want 00", data_o); else passed++;
    checks++; if (data_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", data_valid_o); else passed++;
    checks++; if (locked_o !== 1'b0) $display("FAIL rst_locked: got %b want 0", locked_o); else passed++;
    checks++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_o); else passed++;
    checks++; if (offset_o !== 3'd0) $display("FAIL rst_offset: got %0d want 0", offset_o); else passed++;
  endtask

  // Pattern at offset 3: skip, 3x(slip+skip), 4 matches -> lock after edge 44
  task automatic test_search_lock();
    int first_lock;
    do_reset();
    start_stream(3);
    for (int i = 0; i < 11; i++) push_word(8'h6A);
    en_i = 1'b1;
    step();
    first_lock = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (locked_o === 1'b1) begin
        first_lock = i;
        break;
      end
    end
    checks++; if (first_lock != 44) $display("FAIL lock_cycle: locked at cycle %0d want 44", first_lock); else passed++;
    checks++; if (offset_o !== 3'd3) $display("FAIL lock_offset: got %0d want 3", offset_o); else passed++;
  endtask

  // Continues from the lock: last training word, then payload 12, 34
  task automatic test_locked_data();
    exp_q.push_back(8'h6A);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    push_word(8'h12);
    push_word(8'h34);
    repeat (12) step();
    checks++; if (exp_q.size() != 0) $display("FAIL data_count: %0d words not delivered want 0", exp_q.size()); else passed++;
    checks++; if (locked_o !== 1'b1) $display("FAIL data_locked: got %b want 1", locked_o); else passed++;
  endtask

  // All-zero stream: 16th slip attempt on strobe 32 (edge 128) -> FAIL
  task automatic test_fail_relock();
    int first_err;
    int valid_seen;
    do_reset();
    bitq.delete();
    en_i = 1'b1;
    step();
    first_err = -1;
    valid_seen = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (data_valid_o === 1'b1) valid_seen++;
      if (err_o === 1'b1) begin
        first_err = i;
        break;
      end
    end
    checks++; if (first_err != 128) $display("FAIL fail_cycle: err at cycle %0d want 128", first_err); else passed++;
    checks++; if (valid_seen != 0) $display("FAIL fail_valid: %0d pulses want 0", valid_seen); else passed++;
    repeat (5) step();
    checks++; if (err_o !== 1'b1) $display("FAIL fail_hold: err_o=%b want 1", err_o); else passed++;
    relock_i = 1'b1;
    step();
    relock_i = 1'b0;
    checks++; if (err_o !== 1'b0) $display("FAIL relock_err: got %b want 0", err_o); else passed++;
    checks++; if (iddr_clear_o !== 1'b0) $display("FAIL relock_clear: got %b want 0", iddr_clear_o); else passed++;
    checks++; if (locked_o !== 1'b0) $display("FAIL relock_locked: got %b want 0", locked_o); else passed++;
  endtask

  // Offset 0: two matches, corrupt word slips to offset 1; four fresh matches lock at edge 36
  task automatic test_verify_slip();
    int first_lock;
    do_reset();
    start_stream(0);
    push_word(8'h6A);
    push_word(8'h6A);
    push_word(8'h6A);
    push_word(8'h6B);
    push_zeros(7);
    for (int i = 0; i < 6; i++) push_word(8'h6A);
    en_i = 1'b1;
    step();
    first_lock = -1;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (i == 16) begin
        checks++; if (offset_o !== 3'd1) $display("FAIL slip_offset: got %0d want 1", offset_o); else passed++;
      end
      if (locked_o === 1'b1) begin
        first_lock = i;
        break;
      end
    end
    checks++; if (first_lock != 36) $display("FAIL relock_cycle: locked at cycle %0d want 36", first_lock); else passed++;
    en_i = 1'b0;
    step();
    checks++; if (locked_o !== 1'b0) $display("FAIL disable_locked: got %b want 0", locked_o); else passed++;
    checks++; if (iddr_clear_o !== 1'b1) $display("FAIL disable_clear: got %b want 1", iddr_clear_o); else passed++;
  endtask

  // Offset 2: VERIFY reached at edge 24, second match at 28, reset at edge 29
  task automatic test_reset_mid_verify();
    do_reset();
    start_stream(2);
    for (int i = 0; i < 8; i++) push_word(8'h6A);
    en_i = 1'b1;
    step();
    repeat (28) step();
    checks++; if (offset_o !== 3'd2) $display("FAIL verify_offset: got %0d want 2", offset_o); else passed++;
    checks++; if (locked_o !== 1'b0) $display("FAIL verify_locked: got %b want 0", locked_o); else passed++;
    rst_i = 1'b1;
    step();
    checks++; if (offset_o !== 3'd0) $display("FAIL mrst_offset: got %0d want 0", offset_o); else passed++;
    checks++; if (iddr_clear_o !== 1'b1) $display("FAIL mrst_clear: got %b want 1", iddr_clear_o); else passed++;
    checks++; if (data_o !== 8'h00) $display("FAIL mrst_data: got %h want 00", data_o); else passed++;
    checks++; if ({data_valid_o, locked_o, err_o} !== 3'b000) $display("FAIL mrst_flags: got %b want 000", {data_valid_o, locked_o, err_o}); else passed++;
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_search_lock();
    test_locked_data();
    test_fail_relock();
    test_verify_slip();
    test_reset_mid_verify();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
